// File: rtl/fp_pkg.sv
// Shared widths, derived constants and types for the pipelined IEEE-754 adder/subtractor.
package fp_pkg;

   localparam int unsigned EXP_W_DEF = 8;
   localparam int unsigned MAN_W_DEF = 23;

   localparam int unsigned BIAS_DEF    = (1 << (EXP_W_DEF - 1)) - 1;
   localparam int unsigned EXP_MAX_DEF = (1 << EXP_W_DEF) - 1;
   localparam logic [EXP_W_DEF+MAN_W_DEF:0] QNAN_DEF =
      {1'b0, {EXP_W_DEF{1'b1}}, 1'b1, {(MAN_W_DEF-1){1'b0}}};

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic invalid;
      logic inexact;
   } fp_flags_t;

   function automatic int unsigned bias(input int unsigned ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   function automatic int unsigned exp_max(input int unsigned ew);
      return (1 << ew) - 1;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] value,
   output logic [CNT_W-1:0] count
);

   // Ascending scan: the highest set bit is written last and wins.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (value[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage IEEE-754 add/subtract (unpack, align, add/normalise, round/pack)
// with DAZ/FTZ, round-to-nearest-even and a global valid/ready stall.
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = EXP_W_DEF,
   parameter int unsigned MAN_W = MAN_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic                   is_sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic                   overflow,
   output logic                   underflow,
   output logic                   invalid,
   output logic                   inexact
);

   localparam int unsigned W     = 1 + EXP_W + MAN_W;
   localparam int unsigned SIG_W = MAN_W + 4;
   localparam int unsigned SUM_W = MAN_W + 5;
   localparam int unsigned XE_W  = EXP_W + 1;
   localparam int unsigned LZ_W  = $clog2(MAN_W + 3);
   localparam logic [XE_W-1:0] EXP_TOP = XE_W'(exp_max(EXP_W));
   localparam logic [W-1:0]    QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [W-2:0]    INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

   typedef struct packed {
      logic       hit;
      logic [W-1:0] res;
      fp_flags_t  flg;
   } spec_t;

   typedef struct packed {
      spec_t            sp;
      logic             s;
      logic             eff_sub;
      logic [EXP_W-1:0] e;
      logic [MAN_W:0]   mx;
      logic [MAN_W:0]   my;
      logic [EXP_W-1:0] d;
   } s1_t;

   typedef struct packed {
      spec_t            sp;
      logic             s;
      logic             eff_sub;
      logic [EXP_W-1:0] e;
      logic [SIG_W-1:0] xs;
      logic [SIG_W-1:0] ys;
   } s2_t;

   typedef struct packed {
      spec_t            sp;
      logic             s;
      logic             uf;
      logic [XE_W-1:0]  e;
      logic [SIG_W-1:0] sig;
   } s3_t;

   function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
      if (e == '0) return ZERO;
      if (e == '1) return (f == '0) ? INF : NAN;
      return NORM;
   endfunction

   logic      advance;
   logic      v1, v2, v3;
   s1_t       r1, n1;
   s2_t       r2, n2;
   s3_t       r3, n3;
   logic [W-1:0] n_res;
   fp_flags_t n_flg, flg_q;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // S1: classify, DAZ, order by magnitude, detect specials
   logic             s_a, s_b, a_big;
   logic [EXP_W-1:0] e_a, e_b;
   logic [MAN_W-1:0] f_a, f_b;
   fp_class_e        c_a, c_b;

   always_comb begin
      s_a = a[W-1];
      s_b = b[W-1] ^ is_sub;
      e_a = a[W-2:MAN_W];
      e_b = b[W-2:MAN_W];
      c_a = classify(e_a, a[MAN_W-1:0]);
      c_b = classify(e_b, b[MAN_W-1:0]);
      f_a = (c_a == ZERO) ? '0 : a[MAN_W-1:0];
      f_b = (c_b == ZERO) ? '0 : b[MAN_W-1:0];
      a_big = {e_a, f_a} >= {e_b, f_b};
      n1 = '0;
      n1.eff_sub = s_a ^ s_b;
      if (a_big) begin
         n1.s  = s_a;
         n1.e  = e_a;
         n1.mx = {c_a != ZERO, f_a};
         n1.my = {c_b != ZERO, f_b};
         n1.d  = e_a - e_b;
      end else begin
         n1.s  = s_b;
         n1.e  = e_b;
         n1.mx = {c_b != ZERO, f_b};
         n1.my = {c_a != ZERO, f_a};
         n1.d  = e_b - e_a;
      end
      n1.sp.hit = 1'b1;
      if (c_a == NAN || c_b == NAN) begin
         n1.sp.res         = QNAN;
         n1.sp.flg.invalid = 1'b1;
      end else if (c_a == INF && c_b == INF) begin
         if (s_a == s_b) begin
            n1.sp.res = {s_a, INF_MAG};
         end else begin
            n1.sp.res         = QNAN;
            n1.sp.flg.invalid = 1'b1;
         end
      end else if (c_a == INF) begin
         n1.sp.res = {s_a, INF_MAG};
      end else if (c_b == INF) begin
         n1.sp.res = {s_b, INF_MAG};
      end else begin
         n1.sp.hit = 1'b0;
      end
   end

   // S2: align Y; the LSB collects everything shifted past it as sticky
   logic [EXP_W-1:0] sh;
   logic [SIG_W-1:0] y_full, y_shift;
   logic             lost;

   always_comb begin
      sh      = (32'(r1.d) > MAN_W + 3) ? EXP_W'(MAN_W + 3) : r1.d;
      y_full  = {r1.my, 3'b000};
      y_shift = y_full >> sh;
      lost    = |(y_full & ~({SIG_W{1'b1}} << sh));
      n2         = '0;
      n2.sp      = r1.sp;
      n2.s       = r1.s;
      n2.eff_sub = r1.eff_sub;
      n2.e       = r1.e;
      n2.xs      = {r1.mx, 3'b000};
      n2.ys      = {y_shift[SIG_W-1:1], y_shift[0] | lost};
   end

   // S3: add/subtract and normalise. Only d<=1 can cancel deeply, and then R/S
   // are zero, so counting over hidden..guard is sufficient.
   logic [SUM_W-1:0] sum;
   logic [LZ_W-1:0]  lz;

   assign sum = r2.eff_sub ? ({1'b0, r2.xs} - {1'b0, r2.ys}) : ({1'b0, r2.xs} + {1'b0, r2.ys});

   fp_lzc #(.WIDTH(MAN_W + 2)) u_lzc (
      .value (sum[SIG_W-1:2]),
      .count (lz)
   );

   always_comb begin
      n3     = '0;
      n3.sp  = r2.sp;
      n3.s   = r2.s;
      if (sum[SUM_W-1]) begin
         n3.sig = {sum[SUM_W-1:2], sum[1] | sum[0]};
         n3.e   = {1'b0, r2.e} + 1'b1;
      end else if (sum == '0) begin
         if (r2.eff_sub) n3.s = 1'b0;
      end else if (32'(lz) >= 32'(r2.e)) begin
         n3.uf = 1'b1;
      end else begin
         n3.sig = sum[SIG_W-1:0] << lz;
         n3.e   = {1'b0, r2.e} - XE_W'(lz);
      end
   end

   // S4: round to nearest even and pack
   logic            g, rb, st, inc;
   logic [MAN_W+1:0] rnd;
   logic [XE_W-1:0] e_r;
   logic [MAN_W-1:0] frac;

   always_comb begin
      g     = r3.sig[2];
      rb    = r3.sig[1];
      st    = r3.sig[0];
      inc   = g & (rb | st | r3.sig[3]);
      rnd   = {1'b0, r3.sig[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, inc};
      e_r   = r3.e + {{(XE_W-1){1'b0}}, rnd[MAN_W+1]};
      frac  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      n_flg = '0;
      if (r3.sp.hit) begin
         n_res = r3.sp.res;
         n_flg = r3.sp.flg;
      end else if (r3.uf) begin
         n_res           = {r3.s, {(W-1){1'b0}}};
         n_flg.underflow = 1'b1;
         n_flg.inexact   = 1'b1;
      end else if (e_r >= EXP_TOP) begin
         n_res          = {r3.s, INF_MAG};
         n_flg.overflow = 1'b1;
         n_flg.inexact  = 1'b1;
      end else begin
         n_res         = {r3.s, e_r[EXP_W-1:0], frac};
         n_flg.inexact = g | rb | st;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         r1        <= '0;
         r2        <= '0;
         r3        <= '0;
         result    <= '0;
         flg_q     <= '0;
      end else if (advance) begin
         v1        <= in_valid;
         v2        <= v1;
         v3        <= v2;
         out_valid <= v3;
         r1        <= n1;
         r2        <= n2;
         r3        <= n3;
         result    <= n_res;
         flg_q     <= n_flg;
      end
   end

   assign overflow  = flg_q.overflow;
   assign underflow = flg_q.underflow;
   assign invalid   = flg_q.invalid;
   assign inexact   = flg_q.inexact;

endmodule
